// File: rtl/ubanpr_pkg.sv
// ubanpr_pkg: shared types and constants for the UBA NPR arbiter.
//   - npr_state_t : engine state encoding
//   - RDFLAGS / WRFLAGS : left-half address flags for backplane read / write
//   - bit positions in Verilog numbering (KS10 bit n == Verilog bit 35-n)
package ubanpr_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WRADDR,
        WRRDWAIT,
        WRRDREQ,
        WRPAUSE,
        WRWAIT,
        WRREQ,
        RDADDR,
        RDWAIT,
        RDREQ,
        DONE
    } npr_state_t;

    localparam logic [17:0] RDFLAGS = 18'o040000;
    localparam logic [17:0] WRFLAGS = 18'o010000;

    // pager flag bits
    localparam int FLG_RPW = 0;
    localparam int FLG_FTM = 1;

    // address word bits (KS10 bit 3, 5, 17, 34)
    localparam int ADR_RD  = 35 - 3;
    localparam int ADR_WR  = 35 - 5;
    localparam int ADR_IO  = 35 - 17;
    localparam int ADR_ODD = 35 - 34;

endpackage

// File: rtl/ubanpr_rrarb.sv
// ubanpr_rrarb: round-robin priority encoder with a registered pointer.
//   clk, rst : clock, async active-low reset (pointer -> 0)
//   req      : per-device request vector
//   en       : arbitration allowed this cycle
//   gnt      : first requesting index at or after the pointer, wrapping
//   vld      : some device is requesting
//   adv      : pointer moves to gnt+1 this cycle (en & vld)
module ubanpr_rrarb #(
    parameter int NDEV = 4,
    localparam int IW  = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NDEV-1:0] req,
    input  logic            en,
    output logic [IW-1:0]   gnt,
    output logic            vld,
    output logic            adv
);

    logic [IW-1:0] ptr;

    // Scan from the farthest slot back to ptr so the nearest hit wins.
    always_comb begin
        int            j;
        logic [IW-1:0] jw;
        vld = 1'b0;
        gnt = '0;
        j   = 0;
        jw  = '0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NDEV) j = j - NDEV;
            jw = IW'(j);
            if (req[jw]) begin
                vld = 1'b1;
                gnt = jw;
            end
        end
    end

    assign adv = en & vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (adv)
            ptr <= (int'(gnt) == NDEV - 1) ? '0 : gnt + IW'(1);
    end

endmodule

// File: rtl/uba_npr_arb.sv
// uba_npr_arb: round-robin NPR (DMA) engine for NDEV Unibus devices plus the
// maintenance loopback path, driving the KS10 backplane bus.
//   clk, rst            : clock, async active-low reset
//   regUBAMR            : maintenance mode (loopback only, devices blocked)
//   pageFLAGS/pageADDR  : pager output for the latched address
//   busADDRI/DATAI/ACKI : backplane inputs (busADDRI also carries busIO)
//   busADDRO/DATAO/REQO : backplane outputs
//   loopREAD/WRITE/ACKO : maintenance loopback handshake
//   devREQI/ADDRI/DATAI : per-device request, address, write data (36 bits each)
//   devACKO / devNXMO   : per-device completion / timeout pulses
//   busy                : engine not idle
module uba_npr_arb
    import ubanpr_pkg::*;
#(
    parameter int NDEV  = 4,
    parameter int TOCNT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regUBAMR,
    input  logic [3:0]       pageFLAGS,
    input  logic [35:0]      pageADDR,
    input  logic [35:0]      busADDRI,
    input  logic [35:0]      busDATAI,
    input  logic             busACKI,
    output logic [35:0]      busADDRO,
    output logic [35:0]      busDATAO,
    output logic             busREQO,
    input  logic             loopREAD,
    input  logic             loopWRITE,
    output logic             loopACKO,
    input  logic [NDEV-1:0]  devREQI,
    input  logic [36*NDEV-1:0] devADDRI,
    input  logic [36*NDEV-1:0] devDATAI,
    output logic [NDEV-1:0]  devACKO,
    output logic [NDEV-1:0]  devNXMO,
    output logic             busy
);

    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    npr_state_t state, state_nxt;

    logic [NDEV-1:0][35:0] daddr, ddata;
    assign daddr = devADDRI;
    assign ddata = devDATAI;

    logic          arb_en, gnt_vld, ptr_adv;
    logic [IW-1:0] gnt_idx;

    logic          is_dev;   // current cycle belongs to a device (else loopback)
    logic [IW-1:0] req_dev;
    logic [15:0]   tocnt;

    logic [35:0] gaddr;
    logic        g_rd, g_wr, dev_go;
    logic        busio, odd, rpw, ftm, tmo;

    // next values of the registered outputs / datapath
    logic [35:0]     n_addr, n_data;
    logic            n_req, n_lack, n_isdev;
    logic [NDEV-1:0] n_dack, n_dnxm;
    logic [IW-1:0]   n_dev;
    logic [15:0]     n_cnt;

    assign arb_en = (state == IDLE) && !regUBAMR;

    ubanpr_rrarb #(.NDEV(NDEV)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (devREQI),
        .en  (arb_en),
        .gnt (gnt_idx),
        .vld (gnt_vld),
        .adv (ptr_adv)
    );

    // A pick with neither or both direction flags still moves the pointer
    // but starts no cycle.
    assign gaddr  = daddr[gnt_idx];
    assign g_rd   = gaddr[ADR_RD];
    assign g_wr   = gaddr[ADR_WR];
    assign dev_go = ptr_adv & (g_rd ^ g_wr);

    assign busio = busADDRI[ADR_IO];
    assign odd   = busADDRO[ADR_ODD];
    assign rpw   = pageFLAGS[FLG_RPW];
    assign ftm   = pageFLAGS[FLG_FTM];
    assign tmo   = (tocnt == 16'(TOCNT - 1));
    assign busy  = (state != IDLE);

    logic unused_ok;
    assign unused_ok = ^{gnt_vld, pageFLAGS[3:2], pageADDR[35:18], busADDRI[35:19]};

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (regUBAMR) begin
                    if (loopWRITE)     state_nxt = WRADDR;
                    else if (loopREAD) state_nxt = RDADDR;
                end else if (dev_go) begin
                    state_nxt = g_wr ? WRADDR : RDADDR;
                end
            end
            WRADDR: begin
                if (ftm)
                    state_nxt = is_dev ? WRWAIT : (odd ? WRPAUSE : IDLE);
                else if (!rpw && !odd)
                    state_nxt = WRWAIT;
                else
                    state_nxt = WRRDWAIT;
            end
            WRRDWAIT: if (!busio) state_nxt = WRRDREQ;
            WRWAIT:   if (!busio) state_nxt = WRREQ;
            RDWAIT:   if (!busio) state_nxt = RDREQ;
            WRRDREQ: begin
                if (busACKI)  state_nxt = WRPAUSE;
                else if (tmo) state_nxt = DONE;
            end
            WRREQ, RDREQ: if (busACKI || tmo) state_nxt = DONE;
            WRPAUSE:  state_nxt = WRWAIT;
            RDADDR:   state_nxt = RDWAIT;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // output / datapath next values
    always_comb begin
        n_addr  = busADDRO;
        n_data  = busDATAO;
        n_req   = busREQO;
        n_lack  = 1'b0;
        n_dack  = '0;
        n_dnxm  = '0;
        n_isdev = is_dev;
        n_dev   = req_dev;
        n_cnt   = tocnt;
        case (state)
            IDLE: begin
                if (regUBAMR) begin
                    if (loopWRITE) begin
                        // Loopback write data fills one half of the buffer, so an
                        // even/odd pair under FTM builds a full word.
                        n_lack  = 1'b1;
                        n_isdev = 1'b0;
                        n_addr  = {WRFLAGS, busADDRI[17:0]};
                        if (busADDRI[ADR_ODD]) n_data[17:0]  = busDATAI[17:0];
                        else                   n_data[35:18] = busDATAI[17:0];
                    end else if (loopREAD) begin
                        n_isdev = 1'b0;
                        n_addr  = {RDFLAGS, busADDRI[17:0]};
                    end
                end else if (dev_go) begin
                    n_isdev = 1'b1;
                    n_dev   = gnt_idx;
                    n_addr  = gaddr;
                    n_data  = g_wr ? ddata[gnt_idx] : 36'o0;
                end
            end
            WRADDR: begin
                if (ftm) begin
                    if (!is_dev && odd) n_addr[35:18] = RDFLAGS;
                end else if (!rpw && !odd) begin
                    n_data[17:0] = pageADDR[17:0];
                end else begin
                    n_addr[35:18] = RDFLAGS;
                end
            end
            WRRDWAIT, WRWAIT, RDWAIT: begin
                if (!busio) begin
                    n_req = 1'b1;
                    n_cnt = '0;
                end
            end
            WRRDREQ, WRREQ, RDREQ: begin
                // ACK on the terminal-count cycle still completes normally.
                if (busACKI) begin
                    n_req = 1'b0;
                    if (state == WRRDREQ) begin
                        if (odd) n_data[35:18] = busDATAI[35:18];
                        else     n_data[17:0]  = busDATAI[17:0];
                    end else if (is_dev) begin
                        n_dack[req_dev] = 1'b1;
                    end else if (state == RDREQ) begin
                        n_lack = 1'b1;
                    end
                end else if (tmo) begin
                    n_req = 1'b0;
                    if (is_dev) n_dnxm[req_dev] = 1'b1;
                    else        n_lack = 1'b1;
                end else begin
                    n_cnt = tocnt + 16'd1;
                end
            end
            WRPAUSE: n_addr[35:18] = WRFLAGS;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busADDRO <= '0;
            busDATAO <= '0;
            busREQO  <= 1'b0;
            loopACKO <= 1'b0;
            devACKO  <= '0;
            devNXMO  <= '0;
            is_dev   <= 1'b0;
            req_dev  <= '0;
            tocnt    <= '0;
        end else begin
            busADDRO <= n_addr;
            busDATAO <= n_data;
            busREQO  <= n_req;
            loopACKO <= n_lack;
            devACKO  <= n_dack;
            devNXMO  <= n_dnxm;
            is_dev   <= n_isdev;
            req_dev  <= n_dev;
            tocnt    <= n_cnt;
        end
    end

endmodule

// File: tb/tb_uba_npr_arb.sv
module tb_uba_npr_arb;

    localparam logic [17:0] RDF = 18'o040000;
    localparam logic [17:0] WRF = 18'o010000;

    logic         clk = 1'b0;
    logic         rst;
    logic         regUBAMR;
    logic [3:0]   pageFLAGS;
    logic [35:0]  pageADDR, busADDRI, busDATAI;
    logic         busACKI;
    logic [35:0]  busADDRO, busDATAO;
    logic         busREQO;
    logic         loopREAD, loopWRITE, loopACKO;
    logic [3:0]   devREQI;
    logic [143:0] devADDRI, devDATAI;
    logic [3:0]   devACKO, devNXMO;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // bus responder settings
    bit ack_en  = 1'b0;
    int ack_dly = 1;
    int acnt    = 0;

    // event capture
    logic [35:0] r_addr[$];
    logic [35:0] r_data[$];
    logic [3:0]  q_dack[$];
    logic [3:0]  q_dnxm[$];
    int          n_lack;

    uba_npr_arb #(.NDEV(4), .TOCNT(16)) dut (
        .clk(clk), .rst(rst), .regUBAMR(regUBAMR),
        .pageFLAGS(pageFLAGS), .pageADDR(pageADDR),
        .busADDRI(busADDRI), .busDATAI(busDATAI), .busACKI(busACKI),
        .busADDRO(busADDRO), .busDATAO(busDATAO), .busREQO(busREQO),
        .loopREAD(loopREAD), .loopWRITE(loopWRITE), .loopACKO(loopACKO),
        .devREQI(devREQI), .devADDRI(devADDRI), .devDATAI(devDATAI),
        .devACKO(devACKO), .devNXMO(devNXMO), .busy(busy)
    );

    always #5 clk = ~clk;

    // Backplane slave: ACK ack_dly negedges after it first sees busREQO.
    always @(negedge clk) begin
        if (!ack_en || !busREQO) begin
            busACKI = 1'b0;
            acnt = 0;
        end else if (acnt + 1 >= ack_dly) begin
            busACKI = 1'b1;
            acnt = 0;
        end else begin
            busACKI = 1'b0;
            acnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_watch();
        r_addr.delete(); r_data.delete(); q_dack.delete(); q_dnxm.delete();
        n_lack = 0;
    endtask

    task automatic watch(input int ncyc, input bit drop_busy, input int stop_acks);
        logic prev;
        prev = busREQO;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busREQO && !prev) begin
                r_addr.push_back(busADDRO);
                r_data.push_back(busDATAO);
            end
            prev = busREQO;
            if (devACKO != 4'b0) q_dack.push_back(devACKO);
            if (devNXMO != 4'b0) q_dnxm.push_back(devNXMO);
            if (loopACKO) n_lack++;
            if (drop_busy && busy) devREQI = 4'b0;
            if (stop_acks > 0 && q_dack.size() >= stop_acks) devREQI = 4'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busADDRO, busDATAO, busREQO, loopACKO, devACKO, devNXMO, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%o data=%o req=%b lack=%b ack=%b nxm=%b busy=%b want all 0",
                     busADDRO, busDATAO, busREQO, loopACKO, devACKO, devNXMO, busy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busREQO, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got req=%b busy=%b want 0 0", busREQO, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ack [3];
        logic [35:0] exp_dat [3];
        exp_ack = '{4'b0010, 4'b1000, 4'b0010};
        exp_dat = '{36'o111111_111111, 36'o333333_333333, 36'o111111_111111};
        pageFLAGS = 4'b0010;
        devADDRI[36*1 +: 36] = {WRF, 18'o000100};
        devADDRI[36*3 +: 36] = {WRF, 18'o000300};
        devDATAI[36*1 +: 36] = 36'o111111_111111;
        devDATAI[36*3 +: 36] = 36'o333333_333333;
        ack_en = 1'b1; ack_dly = 2;
        clear_watch();
        devREQI = 4'b1010;
        watch(60, 1'b0, 3);
        devREQI = 4'b0;
        checks++;
        if (q_dack.size() != 3 || r_data.size() != 3) begin
            errors++;
            $display("FAIL rr_count: got acks=%0d reqs=%0d want 3 3", q_dack.size(), r_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_dack[i] !== exp_ack[i]) begin
                    errors++;
                    $display("FAIL rr_ack%0d: got %b want %b", i, q_dack[i], exp_ack[i]);
                end
                checks++;
                if (r_data[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL rr_data%0d: got %o want %o", i, r_data[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_rpw_merge();
        pageFLAGS = 4'b0001;
        devADDRI[36*0 +: 36] = {WRF, 18'o000200};
        devDATAI[36*0 +: 36] = 36'o777777_000000;
        busDATAI = 36'o123456_654321;
        ack_en = 1'b1; ack_dly = 1;
        clear_watch();
        devREQI = 4'b0001;
        watch(30, 1'b1, 0);
        checks++;
        if (r_addr.size() != 2) begin
            errors++;
            $display("FAIL rpw_reqs: got %0d want 2", r_addr.size());
        end else begin
            checks++;
            if (r_addr[0] !== {RDF, 18'o000200}) begin
                errors++;
                $display("FAIL rpw_rdaddr: got %o want %o", r_addr[0], {RDF, 18'o000200});
            end
            checks++;
            if (r_addr[1] !== {WRF, 18'o000200}) begin
                errors++;
                $display("FAIL rpw_wraddr: got %o want %o", r_addr[1], {WRF, 18'o000200});
            end
            checks++;
            if (r_data[1] !== 36'o777777_654321) begin
                errors++;
                $display("FAIL rpw_merge: got %o want %o", r_data[1], 36'o777777_654321);
            end
        end
        checks++;
        if (q_dack.size() != 1 || q_dack[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rpw_ack: got n=%0d first=%b want 1 0001", q_dack.size(),
                     (q_dack.size() > 0) ? q_dack[0] : 4'bx);
        end
    endtask

    task automatic test_loopback();
        pageFLAGS = 4'b0010;
        regUBAMR = 1'b1;
        devADDRI[36*2 +: 36] = {WRF, 18'o000500};
        devREQI = 4'b1111;   // must be ignored in maintenance mode
        ack_en = 1'b1; ack_dly = 1;
        clear_watch();
        busADDRI = {18'o0, 18'o000400};
        busDATAI = {18'o0, 18'o001111};
        loopWRITE = 1'b1;
        @(negedge clk);
        checks++;
        if (loopACKO !== 1'b1) begin
            errors++;
            $display("FAIL loop_wr_even_ack: got %b want 1", loopACKO);
        end
        loopWRITE = 1'b0;
        watch(3, 1'b0, 0);
        busADDRI = {18'o0, 18'o000402};
        busDATAI = {18'o0, 18'o002222};
        loopWRITE = 1'b1;
        @(negedge clk);
        checks++;
        if (loopACKO !== 1'b1) begin
            errors++;
            $display("FAIL loop_wr_odd_ack: got %b want 1", loopACKO);
        end
        loopWRITE = 1'b0;
        busADDRI = 36'o0;
        watch(20, 1'b0, 0);
        checks++;
        if (r_data.size() != 1) begin
            errors++;
            $display("FAIL loop_wr_count: got %0d bus writes want 1", r_data.size());
        end else begin
            checks++;
            if (r_data[0] !== 36'o001111_002222) begin
                errors++;
                $display("FAIL loop_wr_data: got %o want %o", r_data[0], 36'o001111_002222);
            end
            checks++;
            if (r_addr[0] !== {WRF, 18'o000402}) begin
                errors++;
                $display("FAIL loop_wr_addr: got %o want %o", r_addr[0], {WRF, 18'o000402});
            end
        end
        checks++;
        if (q_dack.size() != 0 || n_lack != 0) begin
            errors++;
            $display("FAIL loop_wr_noack: got devacks=%0d loopacks=%0d want 0 0", q_dack.size(), n_lack);
        end
        // loopback read
        clear_watch();
        busADDRI = {18'o0, 18'o000404};
        loopREAD = 1'b1;
        @(negedge clk);
        loopREAD = 1'b0;
        busADDRI = 36'o0;
        watch(20, 1'b0, 0);
        checks++;
        if (r_addr.size() != 1 || r_addr[0] !== {RDF, 18'o000404}) begin
            errors++;
            $display("FAIL loop_rd_addr: got n=%0d addr=%o want 1 %o", r_addr.size(),
                     (r_addr.size() > 0) ? r_addr[0] : 36'bx, {RDF, 18'o000404});
        end
        checks++;
        if (n_lack != 1 || q_dack.size() != 0) begin
            errors++;
            $display("FAIL loop_rd_ack: got loopacks=%0d devacks=%0d want 1 0", n_lack, q_dack.size());
        end
        devREQI = 4'b0;
        regUBAMR = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int w, hi;
        ack_en = 1'b0;
        devADDRI[36*2 +: 36] = {RDF, 18'o000600};
        devDATAI[36*2 +: 36] = 36'o555555_555555;
        devREQI = 4'b0100;
        w = 0;
        while (!busREQO && w < 20) begin
            @(negedge clk);
            if (busy) devREQI = 4'b0;
            w++;
        end
        checks++;
        if (!busREQO) begin
            errors++;
            $display("FAIL to_req: got busREQO=0 after %0d cycles want 1", w);
        end else begin
            checks++;
            if (busADDRO !== {RDF, 18'o000600} || busDATAO !== 36'o0) begin
                errors++;
                $display("FAIL to_rd_bus: got addr=%o data=%o want %o 0", busADDRO, busDATAO, {RDF, 18'o000600});
            end
            hi = 0;
            while (busREQO && hi < 40) begin
                hi++;
                if (devACKO != 4'b0 || devNXMO != 4'b0) hi = 100;
                @(negedge clk);
            end
            checks++;
            if (hi != 16) begin
                errors++;
                $display("FAIL to_req_len: got %0d cycles want 16", hi);
            end
            checks++;
            if (devNXMO !== 4'b0100 || devACKO !== 4'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL to_nxm: got nxm=%b ack=%b busy=%b want 0100 0000 1", devNXMO, devACKO, busy);
            end
            @(negedge clk);
            checks++;
            if (devNXMO !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL to_done: got nxm=%b busy=%b want 0000 0", devNXMO, busy);
            end
        end
    endtask

    task automatic test_busio_hold();
        int w, seen;
        pageFLAGS = 4'b0010;
        devADDRI[36*1 +: 36] = {WRF, 18'o000110};
        ack_en = 1'b1; ack_dly = 1;
        busADDRI = 36'o0;
        busADDRI[18] = 1'b1;   // busIO
        devREQI = 4'b0010;
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        devREQI = 4'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busREQO) seen++;
        end
        checks++;
        if (seen != 0 || !busy) begin
            errors++;
            $display("FAIL io_hold: got req cycles=%0d busy=%b want 0 1", seen, busy);
        end
        busADDRI = 36'o0;
        @(negedge clk);
        checks++;
        if (busREQO !== 1'b1) begin
            errors++;
            $display("FAIL io_release: got busREQO=%b want 1", busREQO);
        end
        clear_watch();
        watch(10, 1'b0, 0);
        checks++;
        if (q_dack.size() != 1 || q_dack[0] !== 4'b0010) begin
            errors++;
            $display("FAIL io_ack: got n=%0d first=%b want 1 0010", q_dack.size(),
                     (q_dack.size() > 0) ? q_dack[0] : 4'bx);
        end
    endtask

    task automatic test_reset_midcycle();
        int w;
        ack_en = 1'b0;
        pageFLAGS = 4'b0001;
        devADDRI[36*2 +: 36] = {WRF, 18'o000210};
        devDATAI[36*2 +: 36] = 36'o246246_246246;
        devREQI = 4'b0100;
        w = 0;
        while (!busREQO && w < 15) begin
            @(negedge clk);
            if (busy) devREQI = 4'b0;
            w++;
        end
        @(negedge clk);
        checks++;
        if (busREQO !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: got busREQO=%b want 1", busREQO);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busADDRO, busDATAO, busREQO, loopACKO, devACKO, devNXMO, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got addr=%o data=%o req=%b busy=%b want all 0",
                     busADDRO, busDATAO, busREQO, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        pageFLAGS = 4'b0010;
        devADDRI[36*0 +: 36] = {WRF, 18'o000010};
        devADDRI[36*3 +: 36] = {WRF, 18'o000030};
        ack_en = 1'b1; ack_dly = 1;
        clear_watch();
        devREQI = 4'b1001;
        watch(20, 1'b0, 1);
        devREQI = 4'b0;
        checks++;
        if (q_dack.size() < 1 || q_dack[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr: got n=%0d first=%b want first 0001", q_dack.size(),
                     (q_dack.size() > 0) ? q_dack[0] : 4'bx);
        end
        watch(10, 1'b0, 0);
    endtask

    task automatic test_bad_flags();
        do_reset();
        ack_en = 1'b1; ack_dly = 1;
        devADDRI[36*0 +: 36] = {RDF | WRF, 18'o000020};
        devADDRI[36*1 +: 36] = {RDF, 18'o000700};
        clear_watch();
        devREQI = 4'b0011;
        watch(30, 1'b0, 1);
        devREQI = 4'b0;
        checks++;
        if (q_dack.size() != 1 || q_dack[0] !== 4'b0010) begin
            errors++;
            $display("FAIL bad_skip_ack: got n=%0d first=%b want 1 0010", q_dack.size(),
                     (q_dack.size() > 0) ? q_dack[0] : 4'bx);
        end
        checks++;
        if (r_addr.size() != 1 || r_addr[0] !== {RDF, 18'o000700} || q_dnxm.size() != 0) begin
            errors++;
            $display("FAIL bad_skip_bus: got reqs=%0d addr=%o nxm=%0d want 1 %o 0", r_addr.size(),
                     (r_addr.size() > 0) ? r_addr[0] : 36'bx, q_dnxm.size(), {RDF, 18'o000700});
        end
    endtask

    initial begin
        rst = 1'b0;
        regUBAMR = 1'b0; pageFLAGS = 4'b0; pageADDR = 36'o0;
        busADDRI = 36'o0; busDATAI = 36'o0; busACKI = 1'b0;
        loopREAD = 1'b0; loopWRITE = 1'b0;
        devREQI = 4'b0; devADDRI = '0; devDATAI = '0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_rpw_merge();
        test_loopback();
        test_timeout();
        test_busio_hold();
        test_reset_midcycle();
        test_bad_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
